// File: rtl/content_grad_update.sv
// One gradient-descent step on a pixel batch toward a content target, plus a
// saturating sum-of-squared-differences loss. LANES pixels are processed per cycle.
module content_grad_update #(
  parameter int SIZE     = 64,
  parameter int LANES    = 4,
  parameter int LR_SHIFT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SIZE-1:0][15:0] content_pixels,
  input  logic [SIZE-1:0][15:0] generated_pixels,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SIZE-1:0][15:0] updated_pixels,
  output logic [31:0]           loss_out,
  output logic                  busy
);

  localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [39:0]           acc_q, acc_d;
  logic [SIZE-1:0][15:0] c_q, c_d;
  logic [SIZE-1:0][15:0] g_q, g_d;
  logic [SIZE-1:0][15:0] upd_q, upd_d;

  logic [IW-1:0]         lane_idx  [LANES];
  logic signed [16:0]    lane_d    [LANES];
  logic signed [16:0]    lane_step [LANES];
  logic [15:0]           lane_upd  [LANES];
  logic [39:0]           lane_sum;

  // Per-lane datapath; the 18-bit update always lands between g and c, so the
  // low 16 bits are the exact result.
  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_idx[l]  = idx_q + IW'(l);
      lane_d[l]    = $signed({1'b0, g_q[lane_idx[l]]}) - $signed({1'b0, c_q[lane_idx[l]]});
      lane_step[l] = lane_d[l] >>> (LR_SHIFT - 1);
      lane_upd[l]  = 16'($signed({2'b00, g_q[lane_idx[l]]}) - 18'(lane_step[l]));
      lane_sum     = lane_sum + 40'($unsigned(34'(lane_d[l]) * 34'(lane_d[l])));
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    c_d     = c_q;
    g_d     = g_q;
    upd_d   = upd_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          c_d     = content_pixels;
          g_d     = generated_pixels;
          idx_d   = '0;
          acc_d   = '0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        for (int l = 0; l < LANES; l++) begin
          upd_d[lane_idx[l]] = lane_upd[l];
        end
        acc_d = acc_q + lane_sum;
        idx_d = idx_q + IW'(LANES);
        if (idx_q == IW'(SIZE - LANES)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      upd_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      upd_q   <= upd_d;
    end
    c_q <= c_d;
    g_q <= g_d;
  end

  assign in_ready       = (state_q == IDLE) && !reset;
  assign out_valid      = (state_q == DONE);
  assign busy           = (state_q == COMPUTE) || (state_q == DONE);
  assign updated_pixels = upd_q;
  assign loss_out       = (|acc_q[39:32]) ? 32'hFFFF_FFFF : acc_q[31:0];

endmodule
